// File: rtl/injection_table_access_arbiter_pkg.sv
// Shared definitions for the injection slot table and the agents that access it.
package injection_table_access_arbiter_pkg;

  // Table geometry and RAM port A read latency
  localparam int unsigned TBL_ADDR_W = 10;
  localparam int unsigned TBL_DATA_W = 16;
  localparam int unsigned TBL_RD_LAT = 2;

  // Table entry field positions (also used by the schedule module)
  localparam int unsigned ENTRY_VALID_BIT = 15;
  localparam int unsigned ENTRY_SLOT_MSB  = 14;
  localparam int unsigned ENTRY_SLOT_LSB  = 5;
  localparam int unsigned ENTRY_INJ_MSB   = 4;
  localparam int unsigned ENTRY_INJ_LSB   = 0;

  // Identity of a requester on the shared table port
  typedef enum logic {
    SRC_REQ0 = 1'b0,
    SRC_REQ1 = 1'b1
  } req_src_e;

  // Read tag travelling alongside the RAM read latency
  typedef struct packed {
    logic     valid;
    req_src_e src;
  } rd_tag_t;

endpackage

// File: rtl/injection_table_access_arbiter_rr_arbiter2.sv
// Two-input round-robin arbiter: grants eligible requesters, alternating on ties.
module rr_arbiter2
  import injection_table_access_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] eligible,
  output logic [1:0] grant,
  output logic       grant_valid,
  output req_src_e   grant_src
);

  req_src_e last;

  // Pick a winner: single eligible requester wins, ties go to the one not granted last
  always_comb begin
    grant = '0;
    if (eligible == 2'b11) begin
      grant = (last == SRC_REQ1) ? 2'b01 : 2'b10;
    end else begin
      grant = eligible;
    end
    grant_valid = |grant;
    grant_src   = grant[1] ? SRC_REQ1 : SRC_REQ0;
  end

  // Remember the last granted requester; reset favours req0 on the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= SRC_REQ1;
    end else if (grant_valid) begin
      last <= grant_src;
    end
  end

endmodule

// File: rtl/injection_table_access_arbiter.sv
// Arbitrates table RAM port A between the config-packet parser (req0) and the
// host register bus (req1); routes read data back to the issuing requester.
module injection_table_access_arbiter
  import injection_table_access_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = TBL_ADDR_W,
  parameter int unsigned DATA_W = TBL_DATA_W,
  parameter int unsigned RD_LAT = TBL_RD_LAT
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req0_wr,
  input  logic              i_req0_rd,
  input  logic [ADDR_W-1:0] iv_req0_addr,
  input  logic [DATA_W-1:0] iv_req0_wdata,
  output logic              o_req0_ack,
  output logic [DATA_W-1:0] ov_req0_rdata,
  output logic              o_req0_rdata_valid,
  input  logic              i_req1_wr,
  input  logic              i_req1_rd,
  input  logic [ADDR_W-1:0] iv_req1_addr,
  input  logic [DATA_W-1:0] iv_req1_wdata,
  output logic              o_req1_ack,
  output logic [DATA_W-1:0] ov_req1_rdata,
  output logic              o_req1_rdata_valid,
  output logic              o_table_wr,
  output logic              o_table_rd,
  output logic [ADDR_W-1:0] ov_table_addr,
  output logic [DATA_W-1:0] ov_table_wdata,
  input  logic [DATA_W-1:0] iv_table_rdata,
  output logic              o_conflict_err
);

  logic [1:0]        eligible;
  logic [1:0]        grant;
  logic              grant_valid;
  req_src_e          grant_src;
  logic              sel_wr;
  logic              sel_rd;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  req_src_e          cmd_src;
  rd_tag_t           tag_pipe [RD_LAT];
  rd_tag_t           tag_out;

  // A requester showing its ack this cycle is not eligible, so it cannot be re-granted
  assign eligible = {(i_req1_wr | i_req1_rd) & ~o_req1_ack,
                     (i_req0_wr | i_req0_rd) & ~o_req0_ack};

  rr_arbiter2 u_arb (
    .clk         (i_clk),
    .rst_n       (i_rst_n),
    .eligible    (eligible),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_src   (grant_src)
  );

  // Select the granted requester's command fields
  always_comb begin
    sel_wr    = i_req0_wr;
    sel_rd    = i_req0_rd;
    sel_addr  = iv_req0_addr;
    sel_wdata = iv_req0_wdata;
    if (grant_src == SRC_REQ1) begin
      sel_wr    = i_req1_wr;
      sel_rd    = i_req1_rd;
      sel_addr  = iv_req1_addr;
      sel_wdata = iv_req1_wdata;
    end
  end

  assign tag_out = tag_pipe[RD_LAT-1];

  // Register the RAM command and ack; wr+rd together performs the write only
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_table_wr     <= 1'b0;
      o_table_rd     <= 1'b0;
      ov_table_addr  <= '0;
      ov_table_wdata <= '0;
      o_req0_ack     <= 1'b0;
      o_req1_ack     <= 1'b0;
      o_conflict_err <= 1'b0;
      cmd_src        <= SRC_REQ0;
    end else begin
      o_table_wr     <= grant_valid & sel_wr;
      o_table_rd     <= grant_valid & sel_rd & ~sel_wr;
      o_conflict_err <= grant_valid & sel_wr & sel_rd;
      o_req0_ack     <= grant[0];
      o_req1_ack     <= grant[1];
      if (grant_valid) begin
        ov_table_addr  <= sel_addr;
        ov_table_wdata <= sel_wdata;
        cmd_src        <= grant_src;
      end
    end
  end

  // Tag shift register: entry pushed with the issued read reaches the end as rdata arrives
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        tag_pipe[i] <= '0;
      end
    end else begin
      tag_pipe[0] <= '{valid: o_table_rd, src: cmd_src};
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  // Capture returning read data for the tagged requester only
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ov_req0_rdata      <= '0;
      ov_req1_rdata      <= '0;
      o_req0_rdata_valid <= 1'b0;
      o_req1_rdata_valid <= 1'b0;
    end else begin
      o_req0_rdata_valid <= tag_out.valid & (tag_out.src == SRC_REQ0);
      o_req1_rdata_valid <= tag_out.valid & (tag_out.src == SRC_REQ1);
      if (tag_out.valid && tag_out.src == SRC_REQ0) begin
        ov_req0_rdata <= iv_table_rdata;
      end
      if (tag_out.valid && tag_out.src == SRC_REQ1) begin
        ov_req1_rdata <= iv_table_rdata;
      end
    end
  end

endmodule

// File: doc/injection_table_access_arbiter.md
Name: injection_table_access_arbiter

Overview:
Shares the configuration port (port A) of the injection slot table RAM between two requesters: req0, the network-management configuration-packet parser, and req1, the local host/CPU register bus.
- Round-robin arbitration, one RAM command per cycle.
- Tracks RAM read latency and routes each read word back to the requester that issued it.
- Sits between both configuration sources and the injection schedule module's table write/read/addr/wdata/rdata ports.

Parameters:
ADDR_W, 10, table address width (1024 entries)
DATA_W, 16, table entry width
RD_LAT, 2, cycles from o_table_rd high to iv_table_rdata valid

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset; one clock, reset asynchronous and active-low
i_req0_wr  in  1  req0 write request, level, held until ack
i_req0_rd  in  1  req0 read request, level, held until ack
iv_req0_addr  in  ADDR_W  req0 address
iv_req0_wdata  in  DATA_W  req0 write data
o_req0_ack  out  1  one-cycle grant acknowledge to req0
ov_req0_rdata  out  DATA_W  read data returned to req0
o_req0_rdata_valid  out  1  one-cycle pulse, ov_req0_rdata valid
i_req1_wr / i_req1_rd / iv_req1_addr / iv_req1_wdata / o_req1_ack / ov_req1_rdata / o_req1_rdata_valid  same as req0, for req1
o_table_wr  out  1  RAM port A write enable
o_table_rd  out  1  RAM port A read enable
ov_table_addr  out  ADDR_W  RAM port A address
ov_table_wdata  out  DATA_W  RAM port A write data
iv_table_rdata  in  DATA_W  RAM port A read data
o_conflict_err  out  1  one-cycle pulse: a granted requester had both wr and rd high

Behaviour:
- Reset values: all outputs 0; grant pointer = req1 (req0 wins the first tie); tag pipeline cleared.
- Request eligibility: reqX is pending when (wr|rd) is high AND o_reqX_ack is low this cycle. A requester cannot be re-granted in the cycle its ack is shown, so each requester gets at most one grant per 2 cycles.
- Arbitration in cycle N (eligible requesters only):
  - none eligible -> no command.
  - one eligible -> grant it.
  - both eligible -> grant the requester not granted last; update the pointer on every grant.
- Grant timing: grant decided in cycle N. In cycle N+1, all registered:
  - o_table_wr/o_table_rd, ov_table_addr, ov_table_wdata driven with the granted requester's values.
  - o_reqX_ack = 1 for exactly that cycle.
- Non-command cycles: o_table_wr = o_table_rd = 0; addr/wdata hold their last value.
- wr and rd both high on a granted requester: perform the write only; o_table_rd = 0; o_conflict_err = 1 in the ack cycle.
- Read return:
  - Each issued read pushes {valid=1, src} into an RD_LAT-deep shift register.
  - Tag emerges in the same cycle iv_table_rdata is valid (cycle N+1+RD_LAT); the word is registered to ov_reqsrc_rdata.
  - o_reqsrc_rdata_valid pulses in cycle N+2+RD_LAT (N+4 at default).
  - The other requester's rdata and valid are unaffected; ov_reqX_rdata holds its last value between pulses.
- Read returns are fully pipelined: back-to-back reads from alternating requesters return in issue order, one per cycle.
- Writes produce no return.
- A write followed by a read of the same address gets the new data (the RAM is read-during-write-new-data on port A; the arbiter adds no hazard logic).
- Reset mid-operation: in-flight tags are discarded, no rdata_valid is produced for them, and a partially acked request is forgotten. The requester must re-request after reset.
- Throughput: with both requesters continuously requesting, grants alternate 0,1,0,1, giving one command per cycle.

Decomposition:
- Shared package (injection table package):
  - ADDR_W = 10, DATA_W = 16, RD_LAT = 2.
  - Entry field positions: valid bit 15, time slot [14:5], injection address [4:0].
  - These are also used by the schedule module.
- Natural sub-module: rr_arbiter2 (2-input round-robin with eligibility masks and pointer). The tag shift register stays inline.

Test Plan:
- req0 write addr 0x005 data 0x8123, alone at cycle 10 -> o_table_wr=1, addr 0x005, wdata 0x8123, o_req0_ack=1 at cycle 11; no rdata_valid.
- req1 read addr 0x005 at cycle 20 (after the write above) -> o_table_rd at 21, o_req1_rdata_valid at 24 with 0x8123; o_req0_rdata_valid stays 0.
- Both hold reads (req0 addr 1, req1 addr 2) for 6 cycles, RAM preloaded addr1=0x1111, addr2=0x2222 -> ack sequence 0,1,0,1,… one per cycle; returns 0x1111→req0 and 0x2222→req1 alternate with no drops.
- req0 drives wr=1 and rd=1, addr 7, wdata 0x00AA -> write only, o_table_rd=0, o_conflict_err pulse coincident with o_req0_ack.
- Reads issued at cycles 30 and 31, i_rst_n low at cycle 32 for 2 cycles -> all outputs 0, no rdata_valid pulses after reset release; first post-reset tie is granted to req0.
